// File: rtl/icache_refill_writer.sv
// Icache refill write-side controller: issues a line read, writes the 8 returned
// beats into the bank RAM write ports, then commits the tag/valid word.
module icache_refill_writer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 5,
  parameter int BANK_NUM = 8
) (
  input  logic                clk_write,
  input  logic                reset,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rlast,
  output logic                mem_rready,
  output logic [BANK_NUM-1:0] bank_write_en,
  output logic [INDEX_W-1:0]  bank_write_addr,
  output logic [DATA_W-1:0]   bank_write_data,
  output logic                tagv_write_en,
  output logic [INDEX_W-1:0]  tagv_write_addr,
  output logic [31:0]         tagv_write_data,
  output logic                refill_done,
  output logic                refill_err,
  output logic                busy
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int CNT_W = $clog2(BANK_NUM);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BANK_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    beat_cnt;
  logic [ADDR_W-1:0]   line_addr;
  logic [INDEX_W-1:0]  line_index;
  logic [BANK_NUM-1:0] bank_onehot;
  logic                beat_take;
  logic                beat_last;
  logic                beat_early;
  logic                unused_offset_bits;

  assign line_index = line_addr[OFFSET_W +: INDEX_W];
  assign beat_take  = (state == RECV) && mem_rvalid;
  assign beat_last  = beat_take && (beat_cnt == LAST_BEAT);
  // Final-count beat wins over rlast; rlast only aborts a short burst.
  assign beat_early = beat_take && mem_rlast && !beat_last;
  assign mem_req_addr = line_addr;
  assign busy = (state != IDLE);
  assign unused_offset_bits = ^miss_addr[OFFSET_W-1:0];

  always_ff @(posedge clk_write) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    miss_ready      = 1'b0;
    mem_req_valid   = 1'b0;
    mem_rready      = 1'b0;
    tagv_write_en   = 1'b0;
    tagv_write_addr = '0;
    tagv_write_data = '0;
    refill_done     = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = RECV;
      end
      RECV: begin
        mem_rready = 1'b1;
        if (beat_last) begin
          state_next = DONE;
        end else if (beat_early) begin
          state_next = IDLE;
        end
      end
      DONE: begin
        tagv_write_en                = 1'b1;
        refill_done                  = 1'b1;
        tagv_write_addr              = line_index;
        tagv_write_data[TAG_W]       = 1'b1;
        tagv_write_data[TAG_W-1:0]   = line_addr[ADDR_W-1 -: TAG_W];
        state_next                   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bank_onehot           = '0;
    bank_onehot[beat_cnt] = 1'b1;
  end

  always_ff @(posedge clk_write) begin
    if (reset) begin
      beat_cnt        <= '0;
      line_addr       <= '0;
      bank_write_en   <= '0;
      bank_write_addr <= '0;
      bank_write_data <= '0;
      refill_err      <= 1'b0;
    end else begin
      bank_write_en <= '0;
      refill_err    <= beat_early;
      if ((state == IDLE) && miss_valid) begin
        line_addr <= {miss_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        beat_cnt  <= '0;
      end
      if (beat_take) begin
        bank_write_en   <= bank_onehot;
        bank_write_addr <= line_index;
        bank_write_data <= mem_rdata;
        beat_cnt        <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_writer.sv
// Directed bench for icache_refill_writer: per-scenario tasks with inline checks
// against hand-computed values; a passive monitor logs write-port activity.
module tb_icache_refill_writer;

  logic        clk_write = 1'b0;
  logic        reset = 1'b1;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rlast = 1'b0;
  logic        mem_rready;
  logic [7:0]  bank_write_en;
  logic [7:0]  bank_write_addr;
  logic [31:0] bank_write_data;
  logic        tagv_write_en;
  logic [7:0]  tagv_write_addr;
  logic [31:0] tagv_write_data;
  logic        refill_done;
  logic        refill_err;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  int          wr_n, tagv_n, done_n, err_n, multi_n, ready_bad;
  logic [7:0]  wr_en   [32];
  logic [7:0]  wr_addr [32];
  logic [31:0] wr_data [32];
  logic [31:0] tagv_data_seen;
  logic [7:0]  tagv_addr_seen;

  icache_refill_writer #(
    .ADDR_W(32), .DATA_W(32), .INDEX_W(8), .OFFSET_W(5), .BANK_NUM(8)
  ) dut (
    .clk_write(clk_write), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .mem_rready(mem_rready),
    .bank_write_en(bank_write_en), .bank_write_addr(bank_write_addr), .bank_write_data(bank_write_data),
    .tagv_write_en(tagv_write_en), .tagv_write_addr(tagv_write_addr), .tagv_write_data(tagv_write_data),
    .refill_done(refill_done), .refill_err(refill_err), .busy(busy)
  );

  always #5 clk_write = ~clk_write;

  always @(negedge clk_write) begin
    if (bank_write_en != 8'h00) begin
      if (wr_n < 32) begin
        wr_en[wr_n]   = bank_write_en;
        wr_addr[wr_n] = bank_write_addr;
        wr_data[wr_n] = bank_write_data;
      end
      wr_n++;
      if ($countones(bank_write_en) > 1) multi_n++;
    end
    if (tagv_write_en) begin
      tagv_n++;
      tagv_data_seen = tagv_write_data;
      tagv_addr_seen = tagv_write_addr;
    end
    if (refill_done) done_n++;
    if (refill_err) err_n++;
    if (miss_valid && busy && miss_ready) ready_bad++;
  end

  task automatic clear_log();
    wr_n = 0; tagv_n = 0; done_n = 0; err_n = 0; multi_n = 0; ready_bad = 0;
    tagv_data_seen = '0; tagv_addr_seen = '0;
  endtask

  task automatic start_miss(input logic [31:0] a, input int wait_cycles);
    @(negedge clk_write); miss_valid = 1'b1; miss_addr = a;
    @(negedge clk_write); miss_valid = 1'b0;
    repeat (wait_cycles) @(negedge clk_write);
    mem_req_ready = 1'b1;
    @(negedge clk_write); mem_req_ready = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [31:0] base, input int gap, input int rlast_at);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1; mem_rdata = base + 32'(i); mem_rlast = (i == rlast_at);
      @(negedge clk_write);
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      repeat (gap) @(negedge clk_write);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk_write);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL %s_idle_timeout got busy=%b want 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_write);
    tests_run++; if (miss_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_miss_ready got %b want 1", miss_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if ({mem_req_valid, mem_rready, tagv_write_en, refill_done, refill_err} !== 5'b0) begin tests_failed++; $display("FAIL reset_strobes got %b want 00000", {mem_req_valid, mem_rready, tagv_write_en, refill_done, refill_err}); end
    tests_run++; if (bank_write_en !== 8'h00) begin tests_failed++; $display("FAIL reset_bank_en got %h want 00", bank_write_en); end
    tests_run++; if ({bank_write_addr, bank_write_data, tagv_write_addr} !== 48'h0) begin tests_failed++; $display("FAIL reset_bank_outputs got %h want 0", {bank_write_addr, bank_write_data, tagv_write_addr}); end
    tests_run++; if (tagv_write_data !== 32'h0) begin tests_failed++; $display("FAIL reset_tagv_data got %h want 0", tagv_write_data); end
    tests_run++; if (mem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_req_addr got %h want 0", mem_req_addr); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_en;
    clear_log();
    @(negedge clk_write); miss_valid = 1'b1; miss_addr = 32'h0000_1A4C;
    @(negedge clk_write);
    tests_run++; if (mem_req_valid !== 1'b1 || miss_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_req_cycle1 got valid=%b ready=%b want 1 0", mem_req_valid, miss_ready); end
    tests_run++; if (mem_req_addr !== 32'h0000_1A40) begin tests_failed++; $display("FAIL basic_req_addr got %h want 00001a40", mem_req_addr); end
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk_write);
    mem_req_ready = 1'b0;
    tests_run++; if (mem_rready !== 1'b1) begin tests_failed++; $display("FAIL basic_rready got %b want 1", mem_rready); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1000_0000; mem_rlast = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      @(negedge clk_write);
      exp_en = 8'h01 << (k - 3);
      tests_run++; if (bank_write_en !== exp_en || bank_write_addr !== 8'hD2 || bank_write_data !== 32'h1000_0000 + 32'(k - 3))
        begin tests_failed++; $display("FAIL basic_bank_c%0d got en=%h addr=%h data=%h want %h d2 %h", k, bank_write_en, bank_write_addr, bank_write_data, exp_en, 32'h1000_0000 + 32'(k - 3)); end
      if (k < 10) begin
        mem_rdata = 32'h1000_0000 + 32'(k - 2); mem_rlast = (k == 9);
      end else begin
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        tests_run++; if (tagv_write_en !== 1'b1 || refill_done !== 1'b1) begin tests_failed++; $display("FAIL basic_done_c10 got tagv_en=%b done=%b want 1 1", tagv_write_en, refill_done); end
        tests_run++; if (tagv_write_data !== 32'h0008_0000 || tagv_write_addr !== 8'hD2) begin tests_failed++; $display("FAIL basic_tagv got data=%h addr=%h want 00080000 d2", tagv_write_data, tagv_write_addr); end
      end
    end
    @(negedge clk_write);
    tests_run++; if (busy !== 1'b0 || miss_ready !== 1'b1 || refill_done !== 1'b0 || bank_write_en !== 8'h00) begin tests_failed++; $display("FAIL basic_c11 got busy=%b ready=%b done=%b en=%h want 0 1 0 00", busy, miss_ready, refill_done, bank_write_en); end
    tests_run++; if (done_n !== 1 || tagv_n !== 1 || multi_n !== 0 || err_n !== 0) begin tests_failed++; $display("FAIL basic_counts got done=%0d tagv=%0d multi=%0d err=%0d want 1 1 0 0", done_n, tagv_n, multi_n, err_n); end
  endtask

  task automatic test_tag_stall();
    int held_bad = 0;
    clear_log();
    @(negedge clk_write); miss_valid = 1'b1; miss_addr = 32'hBFC0_0020;
    @(negedge clk_write); miss_valid = 1'b0;
    for (int w = 0; w < 5; w++) begin
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hBFC0_0020) held_bad++;
      @(negedge clk_write);
    end
    tests_run++; if (held_bad !== 0 || mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_req_held got bad=%0d valid=%b want 0 1", held_bad, mem_req_valid); end
    mem_req_ready = 1'b1;
    @(negedge clk_write); mem_req_ready = 1'b0;
    send_beats(8, 32'hA000_0000, 1, 7);
    wait_idle("stall");
    tests_run++; if (wr_n !== 8 || multi_n !== 0) begin tests_failed++; $display("FAIL stall_strobe_count got %0d multi=%0d want 8 0", wr_n, multi_n); end
    for (int i = 0; i < 8 && i < wr_n; i++) begin
      tests_run++; if (wr_en[i] !== (8'h01 << i) || wr_addr[i] !== 8'h01 || wr_data[i] !== 32'hA000_0000 + 32'(i))
        begin tests_failed++; $display("FAIL stall_bank%0d got en=%h addr=%h data=%h want %h 01 %h", i, wr_en[i], wr_addr[i], wr_data[i], 8'h01 << i, 32'hA000_0000 + 32'(i)); end
    end
    tests_run++; if (tagv_n !== 1 || tagv_data_seen !== 32'h000D_FE00 || tagv_addr_seen !== 8'h01) begin tests_failed++; $display("FAIL stall_tagv got n=%0d data=%h addr=%h want 1 000dfe00 01", tagv_n, tagv_data_seen, tagv_addr_seen); end
  endtask

  task automatic test_early_rlast();
    clear_log();
    start_miss(32'h0000_0BE0, 0);
    send_beats(4, 32'hC0DE_0000, 0, 3);
    tests_run++; if (refill_err !== 1'b1 || miss_ready !== 1'b1 || bank_write_en !== 8'h08) begin tests_failed++; $display("FAIL early_err_cycle got err=%b ready=%b en=%h want 1 1 08", refill_err, miss_ready, bank_write_en); end
    @(negedge clk_write);
    tests_run++; if (refill_err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL early_err_pulse got err=%b busy=%b want 0 0", refill_err, busy); end
    tests_run++; if (wr_n !== 4 || wr_addr[3] !== 8'h5F || wr_data[3] !== 32'hC0DE_0003) begin tests_failed++; $display("FAIL early_banks got n=%0d addr=%h data=%h want 4 5f c0de0003", wr_n, wr_addr[3], wr_data[3]); end
    tests_run++; if (err_n !== 1 || tagv_n !== 0 || done_n !== 0) begin tests_failed++; $display("FAIL early_counts got err=%0d tagv=%0d done=%0d want 1 0 0", err_n, tagv_n, done_n); end
  endtask

  task automatic test_busy_ignore();
    int addr_bad = 0;
    clear_log();
    @(negedge clk_write); miss_valid = 1'b1; miss_addr = 32'h0000_3FA0;
    @(negedge clk_write); miss_addr = 32'h1234_5660;
    repeat (2) begin
      if (miss_ready !== 1'b0 || mem_req_addr !== 32'h0000_3FA0) addr_bad++;
      @(negedge clk_write);
    end
    mem_req_ready = 1'b1;
    @(negedge clk_write); mem_req_ready = 1'b0;
    send_beats(8, 32'h3300_0000, 0, 7);
    tests_run++; if (busy !== 1'b1 || tagv_write_en !== 1'b1) begin tests_failed++; $display("FAIL ignore_done_cycle got busy=%b tagv=%b want 1 1", busy, tagv_write_en); end
    miss_valid = 1'b0;
    @(negedge clk_write);
    @(negedge clk_write);
    tests_run++; if (busy !== 1'b0 || addr_bad !== 0 || ready_bad !== 0) begin tests_failed++; $display("FAIL ignore_state got busy=%b addr_bad=%0d ready_bad=%0d want 0 0 0", busy, addr_bad, ready_bad); end
    tests_run++; if (wr_n !== 8 || wr_addr[0] !== 8'hFD || wr_addr[7] !== 8'hFD) begin tests_failed++; $display("FAIL ignore_banks got n=%0d addr0=%h addr7=%h want 8 fd fd", wr_n, wr_addr[0], wr_addr[7]); end
    tests_run++; if (tagv_n !== 1 || tagv_data_seen !== 32'h0008_0001 || tagv_addr_seen !== 8'hFD) begin tests_failed++; $display("FAIL ignore_tagv got n=%0d data=%h addr=%h want 1 00080001 fd", tagv_n, tagv_data_seen, tagv_addr_seen); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    start_miss(32'h0000_0140, 0);
    send_beats(5, 32'h5555_0000, 0, -1);
    tests_run++; if (bank_write_en !== 8'h10 || bank_write_addr !== 8'h0A) begin tests_failed++; $display("FAIL midreset_beat4 got en=%h addr=%h want 10 0a", bank_write_en, bank_write_addr); end
    reset = 1'b1;
    @(negedge clk_write);
    tests_run++; if (bank_write_en !== 8'h00 || busy !== 1'b0 || miss_ready !== 1'b1 || mem_rready !== 1'b0 || tagv_write_en !== 1'b0)
      begin tests_failed++; $display("FAIL midreset_state got en=%h busy=%b ready=%b rready=%b tagv=%b want 00 0 1 0 0", bank_write_en, busy, miss_ready, mem_rready, tagv_write_en); end
    reset = 1'b0;
    tests_run++; if (wr_n !== 5 || done_n !== 0 || tagv_n !== 0) begin tests_failed++; $display("FAIL midreset_counts got wr=%0d done=%0d tagv=%0d want 5 0 0", wr_n, done_n, tagv_n); end
    clear_log();
    start_miss(32'h0000_1A4C, 0);
    send_beats(8, 32'h7700_0000, 0, 7);
    wait_idle("midreset_after");
    tests_run++; if (done_n !== 1 || tagv_n !== 1 || tagv_data_seen !== 32'h0008_0000 || tagv_addr_seen !== 8'hD2) begin tests_failed++; $display("FAIL midreset_after_tagv got done=%0d tagv=%0d data=%h addr=%h want 1 1 00080000 d2", done_n, tagv_n, tagv_data_seen, tagv_addr_seen); end
    tests_run++; if (wr_n !== 8 || wr_en[7] !== 8'h80 || wr_data[7] !== 32'h7700_0007) begin tests_failed++; $display("FAIL midreset_after_banks got n=%0d en7=%h data7=%h want 8 80 77000007", wr_n, wr_en[7], wr_data[7]); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_tag_stall();
    test_early_rlast();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
